alarm_clock_param: RTL and testbench

ALARM_CLOCK_PARAM -- requirements
Module: alarm_clock_param

---
 rtl/clock_pkg.sv | 49 ++++
 rtl/bcd_time_counter.sv | 59 +++++
 rtl/alarm_clock_param.sv | 138 +++++++++++++
 tb/tb_alarm_clock_param.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared BCD time types, alarm FSM states and BCD arithmetic helpers
// for the alarm clock.
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd_field_t;

    typedef struct packed {
        bcd_field_t hh;
        bcd_field_t mm;
        bcd_field_t ss;
    } bcd_time_t;

    typedef struct packed {
        bcd_field_t hh;
        bcd_field_t mm;
    } bcd_hm_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } alarm_state_t;

    localparam bcd_field_t HH_MAX = 8'h23;
    localparam bcd_field_t MS_MAX = 8'h59;

    // Both digits must be decimal; once they are, BCD order matches numeric order.
    function automatic logic bcd_field_ok(input bcd_field_t f, input bcd_field_t max);
        return (f[7:4] <= 4'd9) && (f[3:0] <= 4'd9) && (f <= max);
    endfunction

    function automatic logic [6:0] bcd_to_bin(input bcd_field_t f);
        return ({3'b000, f[7:4]} * 7'd10) + {3'b000, f[3:0]};
    endfunction

    function automatic bcd_field_t bin_to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic bcd_hm_t bcd_add_minutes(input bcd_hm_t t, input logic [5:0] mins);
        logic [10:0] m;
        m = 11'(bcd_to_bin(t.hh)) * 11'd60 + 11'(bcd_to_bin(t.mm)) + 11'(mins);
        if (m >= 11'd1440)
            m = m - 11'd1440;
        return {bin_to_bcd(7'(m / 11'd60)), bin_to_bcd(7'(m % 11'd60))};
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// 24-hour BCD HH:MM:SS register: guarded load, one-second increment with
// carries, and the incremented value exposed for alarm matching.
module bcd_time_counter
    import clock_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load_i,
    input  bcd_time_t time_i,
    input  logic      inc_i,
    output bcd_time_t time_o,
    output bcd_time_t time_inc_o
);

    bcd_time_t time_q, time_d, time_inc;
    logic      load_ok;

    function automatic bcd_field_t inc_field(input bcd_field_t f, input bcd_field_t max);
        if (f == max)
            return 8'h00;
        else if (f[3:0] == 4'd9)
            return {f[7:4] + 4'd1, 4'd0};
        else
            return {f[7:4], f[3:0] + 4'd1};
    endfunction

    assign load_ok = bcd_field_ok(time_i.hh, HH_MAX) &&
                     bcd_field_ok(time_i.mm, MS_MAX) &&
                     bcd_field_ok(time_i.ss, MS_MAX);

    always_comb begin
        time_inc.ss = inc_field(time_q.ss, MS_MAX);
        time_inc.mm = (time_q.ss == MS_MAX) ? inc_field(time_q.mm, MS_MAX) : time_q.mm;
        time_inc.hh = (time_q.ss == MS_MAX && time_q.mm == MS_MAX)
                    ? inc_field(time_q.hh, HH_MAX) : time_q.hh;
    end

    // An illegal load value simply holds the current time.
    always_comb begin
        time_d = time_q;
        if (load_i) begin
            if (load_ok)
                time_d = time_i;
        end else if (inc_i) begin
            time_d = time_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            time_q <= '0;
        else
            time_q <= time_d;
    end

    assign time_o     = time_q;
    assign time_inc_o = time_inc;

endmodule

// File: rtl/alarm_clock_param.sv
// Alarm clock: seconds prescaler, BCD time-of-day, alarm register with
// snooze, and a 12/24-hour display mapping.
module alarm_clock_param
    import clock_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter int unsigned ALARM_LEN     = 10,
    parameter int unsigned SNOOZE_MIN    = 5
) (
    input  logic        clk,
    input  logic        reset_time,
    input  logic        set_time,
    input  logic [23:0] time_in,
    input  logic        set_alarm,
    input  logic [15:0] alarm_in,
    input  logic        alarm_en,
    input  logic        snooze,
    input  logic        dismiss,
    input  logic        mode_12h,
    output logic [23:0] time_out,
    output logic        pm,
    output logic        alarm_out,
    output logic        sec_tick
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned RW = $clog2(ALARM_LEN + 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    bcd_hm_t       alarm_q, alarm_d;
    bcd_hm_t       snz_q, snz_d;
    alarm_state_t  state_q, state_d;
    logic          sec_tick_q;
    logic          tick, alarm_hit, snz_hit, ring_done;
    bcd_time_t     cur_time, time_inc;
    bcd_field_t    disp_hh;

    assign tick = !set_time && (presc_q == PW'(TICKS_PER_SEC - 1));

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (set_time || tick)
            presc_d = '0;
    end

    bcd_time_counter u_time (
        .clk        (clk),
        .rst        (reset_time),
        .load_i     (set_time),
        .time_i     (bcd_time_t'(time_in)),
        .inc_i      (tick),
        .time_o     (cur_time),
        .time_inc_o (time_inc)
    );

    always_comb begin
        alarm_d = alarm_q;
        if (set_alarm && bcd_field_ok(alarm_in[15:8], HH_MAX) && bcd_field_ok(alarm_in[7:0], MS_MAX))
            alarm_d = bcd_hm_t'(alarm_in);
    end

    // Matches look at the value the increment is about to produce, so a
    // time loaded through set_time can never fire the alarm.
    assign alarm_hit = tick && (time_inc == {alarm_q, 8'h00});
    assign snz_hit   = tick && (time_inc == {snz_q, 8'h00});
    assign ring_done = tick && (ring_cnt_q == RW'(ALARM_LEN - 1));

    always_comb begin
        state_d = state_q;
        if (set_time || !alarm_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (alarm_hit) state_d = ST_RINGING;
                ST_RINGING: begin
                    if (dismiss)        state_d = ST_IDLE;
                    else if (snooze)    state_d = ST_SNOOZED;
                    else if (ring_done) state_d = ST_IDLE;
                end
                ST_SNOOZED: begin
                    if (dismiss)        state_d = ST_IDLE;
                    else if (snz_hit)   state_d = ST_RINGING;
                end
                default:                state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        snz_d = snz_q;
        if (state_q == ST_RINGING && state_d == ST_SNOOZED)
            snz_d = bcd_add_minutes({cur_time.hh, cur_time.mm}, 6'(SNOOZE_MIN));
    end

    always_comb begin
        ring_cnt_d = '0;
        if (state_q == ST_RINGING)
            ring_cnt_d = tick ? ring_cnt_q + RW'(1) : ring_cnt_q;
    end

    always_ff @(posedge clk or posedge reset_time) begin
        if (reset_time) begin
            presc_q    <= '0;
            ring_cnt_q <= '0;
            alarm_q    <= '0;
            snz_q      <= '0;
            state_q    <= ST_IDLE;
            sec_tick_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            ring_cnt_q <= ring_cnt_d;
            alarm_q    <= alarm_d;
            snz_q      <= snz_d;
            state_q    <= state_d;
            sec_tick_q <= tick;
        end
    end

    always_comb begin
        alarm_out = (state_q == ST_RINGING);
    end

    always_comb begin
        disp_hh = cur_time.hh;
        if (mode_12h) begin
            if (cur_time.hh == 8'h00)
                disp_hh = 8'h12;
            else if (cur_time.hh > 8'h12)
                disp_hh = bin_to_bcd(bcd_to_bin(cur_time.hh) - 7'd12);
        end
    end

    assign time_out = {disp_hh, cur_time.mm, cur_time.ss};
    assign pm       = (cur_time.hh >= 8'h12);
    assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_alarm_clock_param.sv
// Bench for alarm_clock_param: seconds-of-day reference model checked against
// a 1 tick/s instance, plus a 4 tick/s instance for the prescaler scenario.
module tb_alarm_clock_param;

    localparam int ALEN = 10;
    localparam int SNZ  = 5;

    logic        clk = 1'b0;
    logic        reset_time, set_time, set_alarm, alarm_en, snooze, dismiss, mode_12h;
    logic [23:0] time_in;
    logic [15:0] alarm_in;
    logic [23:0] time_out, time_out4;
    logic        pm, alarm_out, sec_tick, pm4, alarm_out4, sec_tick4;

    int total = 0;
    int bad   = 0;

    // Reference model state: seconds of day, minutes of day, plain flags.
    int m_sec, m_alarm, m_snz, m_el;
    bit m_ring, m_snzd, m_tick;

    always #5 clk = ~clk;

    alarm_clock_param #(.TICKS_PER_SEC(1), .ALARM_LEN(ALEN), .SNOOZE_MIN(SNZ)) dut (
        .clk(clk), .reset_time(reset_time), .set_time(set_time), .time_in(time_in),
        .set_alarm(set_alarm), .alarm_in(alarm_in), .alarm_en(alarm_en), .snooze(snooze),
        .dismiss(dismiss), .mode_12h(mode_12h), .time_out(time_out), .pm(pm),
        .alarm_out(alarm_out), .sec_tick(sec_tick));

    alarm_clock_param #(.TICKS_PER_SEC(4), .ALARM_LEN(ALEN), .SNOOZE_MIN(SNZ)) dut4 (
        .clk(clk), .reset_time(reset_time), .set_time(set_time), .time_in(time_in),
        .set_alarm(set_alarm), .alarm_in(alarm_in), .alarm_en(alarm_en), .snooze(snooze),
        .dismiss(dismiss), .mode_12h(mode_12h), .time_out(time_out4), .pm(pm4),
        .alarm_out(alarm_out4), .sec_tick(sec_tick4));

    function automatic int bcd2(input logic [7:0] f);
        return int'(f[7:4]) * 10 + int'(f[3:0]);
    endfunction

    function automatic bit ok2(input logic [7:0] f, input int max);
        return (f[7:4] <= 4'd9) && (f[3:0] <= 4'd9) && (bcd2(f) <= max);
    endfunction

    function automatic logic [7:0] tobcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [23:0] enc(input int s, input logic m12);
        int h;
        h = s / 3600;
        if (m12) begin
            if (h == 0) h = 12;
            else if (h > 12) h = h - 12;
        end
        return {tobcd(h), tobcd((s / 60) % 60), tobcd(s % 60)};
    endfunction

    function automatic logic [26:0] exp_vec();
        return {enc(m_sec, mode_12h), (m_sec >= 12 * 3600), m_ring, m_tick};
    endfunction

    task automatic model_reset();
        m_sec = 0; m_alarm = 0; m_snz = 0; m_el = 0;
        m_ring = 0; m_snzd = 0; m_tick = 0;
    endtask

    task automatic model_step();
        int nxt, cur_min;
        bit tk;
        tk      = !set_time;
        nxt     = (m_sec + 1) % 86400;
        cur_min = m_sec / 60;
        if (set_time || !alarm_en) begin
            m_ring = 0; m_snzd = 0;
        end else if (m_ring) begin
            if (dismiss) m_ring = 0;
            else if (snooze) begin
                m_ring = 0; m_snzd = 1; m_snz = (cur_min + SNZ) % 1440;
            end else if (tk) begin
                m_el++;
                if (m_el == ALEN) m_ring = 0;
            end
        end else if (m_snzd) begin
            if (dismiss) m_snzd = 0;
            else if (tk && nxt == m_snz * 60) begin
                m_snzd = 0; m_ring = 1; m_el = 0;
            end
        end else if (tk && nxt == m_alarm * 60) begin
            m_ring = 1; m_el = 0;
        end
        if (set_time) begin
            if (ok2(time_in[23:16], 23) && ok2(time_in[15:8], 59) && ok2(time_in[7:0], 59))
                m_sec = bcd2(time_in[23:16]) * 3600 + bcd2(time_in[15:8]) * 60 + bcd2(time_in[7:0]);
        end else begin
            m_sec = nxt;
        end
        if (set_alarm && ok2(alarm_in[15:8], 23) && ok2(alarm_in[7:0], 59))
            m_alarm = bcd2(alarm_in[15:8]) * 60 + bcd2(alarm_in[7:0]);
        m_tick = tk;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_time = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_time = 1'b0;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic test_reset();
        reset_time = 0; set_time = 0; set_alarm = 0; alarm_en = 0; snooze = 0;
        dismiss = 0; mode_12h = 0; time_in = '0; alarm_in = '0;
        #2 reset_time = 1'b1;
        model_reset();
        #1;
        total++;
        if ({time_out, pm, alarm_out, sec_tick} !== 27'd0) begin
            bad++; $display("FAIL reset_state got=%h want=0", {time_out, pm, alarm_out, sec_tick});
        end
        total++;
        if ({time_out4, pm4, alarm_out4, sec_tick4} !== 27'd0) begin
            bad++; $display("FAIL reset_state4 got=%h want=0", {time_out4, pm4, alarm_out4, sec_tick4});
        end
        // Hold set_time through release so the model and both DUTs start aligned.
        set_time = 1; time_in = 24'h000000;
        @(negedge clk) reset_time = 1'b0;
        step();
    endtask

    task automatic test_rollover();
        set_time = 1; time_in = 24'h235955;
        step();
        set_time = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            total++;
            if ({time_out, pm, alarm_out, sec_tick} !== exp_vec()) begin
                bad++; $display("FAIL rollover[%0d] got=%h want=%h", i, {time_out, pm, alarm_out, sec_tick}, exp_vec());
            end
        end
        total++;
        if (time_out !== 24'h000005) begin
            bad++; $display("FAIL rollover_end got=%h want=000005", time_out);
        end
    endtask

    task automatic test_async_reset();
        set_time = 1; time_in = 24'h123456;
        step();
        total++;
        if (time_out !== 24'h123456) begin
            bad++; $display("FAIL set_load got=%h want=123456", time_out);
        end
        #2 reset_time = 1'b1;
        model_reset();
        #1;
        total++;
        if (time_out !== 24'h000000 || pm !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%h pm=%b want=000000 pm=0", time_out, pm);
        end
        @(posedge clk); #1;
        total++;
        if (time_out !== 24'h000000) begin
            bad++; $display("FAIL reset_priority got=%h want=000000", time_out);
        end
        @(negedge clk) reset_time = 1'b0;
        set_time = 1; time_in = 24'h000000;
        step();
    endtask

    task automatic test_12h_presc();
        mode_12h = 1; set_time = 1; time_in = 24'h130500;
        step();
        set_time = 0;
        total++;
        if (time_out4 !== 24'h010500 || pm4 !== 1'b1) begin
            bad++; $display("FAIL h12_disp got=%h pm=%b want=010500 pm=1", time_out4, pm4);
        end
        for (int k = 1; k <= 13; k++) begin
            step();
            total++;
            if ({time_out4, pm4, sec_tick4} !== {enc(13 * 3600 + 5 * 60 + k / 4, 1'b1), 1'b1, (k % 4 == 0)}) begin
                bad++; $display("FAIL presc4[%0d] got=%h tick=%b want=%h tick=%b", k, time_out4, sec_tick4,
                                enc(13 * 3600 + 5 * 60 + k / 4, 1'b1), (k % 4 == 0));
            end
            total++;
            if ({time_out, pm, alarm_out, sec_tick} !== exp_vec()) begin
                bad++; $display("FAIL h12_model[%0d] got=%h want=%h", k, {time_out, pm, alarm_out, sec_tick}, exp_vec());
            end
        end
        mode_12h = 0;
    endtask

    task automatic test_alarm();
        alarm_en = 1; set_alarm = 1; alarm_in = 16'h0700; set_time = 1; time_in = 24'h065958;
        step();
        set_alarm = 0; set_time = 0;
        for (int i = 1; i <= 14; i++) begin
            step();
            total++;
            if (alarm_out !== (i >= 2 && i < 12) || alarm_out !== m_ring) begin
                bad++; $display("FAIL alarm_ring[%0d] t=%h got=%b want=%b", i, time_out, alarm_out, (i >= 2 && i < 12));
            end
        end
        // Ring again and drop it with an asynchronous reset mid-cycle.
        set_time = 1; time_in = 24'h065959;
        step();
        set_time = 0;
        step();
        total++;
        if (alarm_out !== 1'b1) begin
            bad++; $display("FAIL alarm_rering got=%b want=1", alarm_out);
        end
        #2 reset_time = 1'b1;
        model_reset();
        #1;
        total++;
        if (alarm_out !== 1'b0) begin
            bad++; $display("FAIL reset_mid_ring got=%b want=0", alarm_out);
        end
        set_time = 1; time_in = 24'h000000;
        @(negedge clk) reset_time = 1'b0;
        step();
    endtask

    task automatic test_snooze();
        int guard;
        alarm_en = 1; set_alarm = 1; alarm_in = 16'h2358; set_time = 1; time_in = 24'h235759;
        step();
        set_alarm = 0; set_time = 0;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (alarm_out !== 1'b1 || time_out !== 24'h235803) begin
            bad++; $display("FAIL snz_ringing got=%b t=%h want=1 t=235803", alarm_out, time_out);
        end
        snooze = 1;
        step();
        snooze = 0;
        total++;
        if (alarm_out !== 1'b0) begin
            bad++; $display("FAIL snz_drop got=%b want=0", alarm_out);
        end
        guard = 0;
        while (time_out !== 24'h000300 && guard < 400) begin
            step();
            guard++;
            total++;
            if ({time_out, pm, alarm_out, sec_tick} !== exp_vec()) begin
                bad++; $display("FAIL snz_wait[%0d] got=%h want=%h", guard, {time_out, pm, alarm_out, sec_tick}, exp_vec());
            end
        end
        total++;
        if (time_out !== 24'h000300 || alarm_out !== 1'b1) begin
            bad++; $display("FAIL snz_rering t=%h got=%b want=000300 1", time_out, alarm_out);
        end
        step(); step();
        snooze = 1; dismiss = 1;
        step();
        snooze = 0; dismiss = 0;
        total++;
        if (alarm_out !== 1'b0) begin
            bad++; $display("FAIL snz_dismiss got=%b want=0", alarm_out);
        end
        for (int i = 0; i < 320; i++) begin
            step();
            total++;
            if (alarm_out !== m_ring) begin
                bad++; $display("FAIL dismiss_wins[%0d] t=%h got=%b want=%b", i, time_out, alarm_out, m_ring);
            end
        end
    endtask

    task automatic test_illegal();
        logic [23:0] bad_t [3];
        bad_t[0] = 24'h240000; bad_t[1] = 24'h126000; bad_t[2] = 24'h1A0000;
        set_time = 1; time_in = 24'h101010;
        step();
        for (int i = 0; i < 3; i++) begin
            time_in = bad_t[i];
            step();
            total++;
            if (time_out !== 24'h101010) begin
                bad++; $display("FAIL illegal_time[%0d] got=%h want=101010", i, time_out);
            end
        end
        alarm_en = 1; set_alarm = 1; alarm_in = 16'h0700;
        step();
        alarm_in = 16'h2500;
        step();
        set_alarm = 0; time_in = 24'h070000;
        step();
        set_time = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (alarm_out !== 1'b0 || alarm_out !== m_ring) begin
                bad++; $display("FAIL no_alarm_on_load[%0d] got=%b want=0", i, alarm_out);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            set_time  = ($urandom_range(0, 39) == 0);
            time_in   = ($urandom_range(0, 3) == 0) ? 24'($urandom())
                        : {tobcd($urandom_range(0, 23)), tobcd($urandom_range(0, 59)), tobcd($urandom_range(50, 59))};
            set_alarm = ($urandom_range(0, 29) == 0);
            alarm_in  = ($urandom_range(0, 3) == 0) ? 16'($urandom())
                        : {tobcd(((m_sec / 60 + 1) % 1440) / 60), tobcd((m_sec / 60 + 1) % 60)};
            alarm_en  = ($urandom_range(0, 49) != 0);
            snooze    = ($urandom_range(0, 11) == 0);
            dismiss   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) mode_12h = ~mode_12h;
            step();
            total++;
            if ({time_out, pm, alarm_out, sec_tick} !== exp_vec()) begin
                bad++; $display("FAIL random[%0d] got=%h want=%h", i, {time_out, pm, alarm_out, sec_tick}, exp_vec());
            end
        end
        set_time = 0; set_alarm = 0; snooze = 0; dismiss = 0;
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_async_reset();
        test_12h_presc();
        test_alarm();
        test_snooze();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
